seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Holds one BCD nibble plus one decimal point per digit and shares a single BCD-to-7-segment decoder across all digits.
- Steps through the digits with a programmable dwell time and a blanking gap between digits to suppress ghosting.
- New display values come in through a double-buffered load handshake and take effect only at frame boundaries, so a frame never shows a mix of old and new values.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 50000, clk cycles per digit slot, blank gap included.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off. Constraint: 1 <= BLANK_CYCLES < PRESCALE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- load  in  1  request to capture digits_in/dp_in/lzb_en
- digits_in  in  4*NUM_DIGITS  BCD nibbles; digit 0 = bits [3:0] = rightmost digit
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- lzb_en  in  1  leading-zero blanking enable (captured with load)
- ready  out  1  high when the pending buffer is empty and load will be accepted
- seg  out  8  segment drive, active-low, bit7 = dp, bits6:0 = g..a
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low while showing
- digit_idx  out  clog2(NUM_DIGITS)  index of the digit being driven

Behaviour:
- Reset (async, rst=1): state=BLANK, digit_idx=0, slot counter=0, an=all 1, seg=8'hFF, active and pending registers cleared (digits 0, dp 0, lzb 0), pending_valid=0, ready=1.
- Reset mid-frame forces these values immediately, with no completion of the current slot.
- FSM has two states.
  - BLANK: an=all 1, seg=8'hFF. Lasts BLANK_CYCLES cycles, then goes to SHOW.
  - SHOW: an[digit_idx]=0, all other anodes 1; seg=decoded value. Lasts PRESCALE-BLANK_CYCLES cycles, then goes to BLANK and digit_idx increments.
- digit_idx wraps from NUM_DIGITS-1 to 0. Frame length = NUM_DIGITS*PRESCALE cycles.
- seg and an are registered and change on the same edge that enters the state. No combinational path from inputs to outputs.
- Decode rules:
  - Nibble 0..9 gives the standard common-anode pattern (e.g. 0 -> 7'b1000000, 8 -> 7'b0000000).
  - Nibble 10..15 gives 7'b1111111 (blank).
  - seg[7] = ~dp of the active digit, regardless of the nibble value.
- Leading-zero blanking, when active lzb=1:
  - Digit i is blanked (seg[6:0]=7'h7F) if digit i and all higher digits are 0.
  - Digit 0 is never blanked.
  - dp still shows on a blanked digit.
  - The anode still enables, so scan timing is unchanged.
- Handshake:
  - load && ready captures the inputs into the pending buffer and sets pending_valid. ready = ~pending_valid, registered, so it goes low the next cycle.
  - load while ready=0 is ignored.
- Frame boundary = the SHOW->BLANK edge of digit NUM_DIGITS-1. At that edge:
  - If pending_valid, pending is copied to active and pending_valid clears, so ready rises the next cycle.
  - The new values are first visible on digit 0 of the new frame.
- Boundary edge with load && ready in the same cycle: the capture goes to pending and no transfer happens on that edge. The data is shown from the next boundary.

Decomposition:
- Shared package: SEG_BLANK=8'hFF, AN_OFF helper, the BCD->segment constant table, and the scan state enum {BLANK, SHOW}.
- One sub-module: bcd_seg_dec, a combinational 4-bit -> 8-bit decoder using the same table, instantiated once and fed from the active-digit mux.
- Scan FSM, slot counter, buffers and leading-zero logic stay in seg_scan_ctrl.

Test Plan (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2):
1. Reset, then 40 cycles with no load.
   -> an cycles 1111 x2 / 1110 x6 / 1111 x2 / 1101 x6 / ... through 0111.
   -> seg=8'hC0 in every SHOW, 8'hFF in every BLANK; ready=1.
2. load with digits=16'h1234, dp=4'b0100, lzb=0.
   -> ready low until the next boundary.
   -> Next frame: digit0 seg=8'h99, digit1 8'hB0, digit2 8'h24 (dp lit), digit3 8'hF9.
3. digits=16'h0050, lzb=1.
   -> digit3 and digit2 seg=8'hFF, digit1 8'h92, digit0 8'hC0.
   -> Same digits with lzb=0: digit3 and digit2 = 8'hC0.
4. load 16'h1111, then load 16'h2222 while ready=0, before the boundary.
   -> 16'h2222 is ignored and frame shows 1111.
   -> A load issued in the boundary cycle is shown one frame later.
5. Nibble 4'hA on digit1 with dp=1 -> seg=8'h7F during digit1's SHOW.
6. Assert rst for 1 cycle during digit2's SHOW.
   -> an=1111 and seg=8'hFF immediately; digit_idx=0; active data cleared.
   -> Scan restarts at BLANK of digit 0.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller.
// Contents: scan state enum, blank segment/anode constants, anode select helper
// and the BCD -> 7-segment (active-low, common-anode) lookup.
package seg_scan_ctrl_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;  // all segments and dp off
    localparam logic [6:0] SEG_OFF   = 7'h7F;  // segments a..g off, dp untouched

    // All anodes off (active-low). Callers slice to their digit count.
    function automatic logic [7:0] an_off();
        return 8'hFF;
    endfunction

    // One-hot-low anode pattern selecting digit idx.
    function automatic logic [7:0] an_sel(input logic [2:0] idx);
        logic [7:0] r;
        r      = an_off();
        r[idx] = 1'b0;
        return r;
    endfunction

    // Bits 6:0 = g..a, active-low. Non-BCD codes render blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_bcd_seg_dec.sv
// bcd_seg_dec: combinational BCD nibble + decimal point -> active-low segment byte.
// Ports:
//   bcd  in  4  BCD nibble (10..15 decode to blank)
//   dp   in  1  decimal point, 1 = lit
//   seg  out 8  bit7 = dp, bits6:0 = g..a, active-low
module bcd_seg_dec
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {~dp, bcd_to_seg(bcd)};

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display with a double-buffered load interface.
// Ports:
//   clk        in   1             system clock
//   rst        in   1             asynchronous reset, active-high
//   load       in   1             capture digits_in/dp_in/lzb_en when ready
//   digits_in  in   4*NUM_DIGITS  BCD nibbles, digit 0 = bits [3:0] = rightmost
//   dp_in      in   NUM_DIGITS    decimal points, 1 = lit
//   lzb_en     in   1             leading-zero blanking enable
//   ready      out  1             pending buffer empty, load will be accepted
//   seg        out  8             segments, active-low, bit7 = dp
//   an         out  NUM_DIGITS    anodes, active-low
//   digit_idx  out  clog2(N)      digit currently being driven
//
// Handshake: a transfer happens on any cycle where load && ready; ready drops
// the following cycle and stays low until the captured values move into the
// active buffer at the next frame boundary (SHOW->BLANK of the last digit).
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          lzb_en,
    output logic                          ready,
    output logic [7:0]                    seg,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int IDX_W       = $clog2(NUM_DIGITS);
    localparam int CNT_W       = $clog2(PRESCALE);
    localparam int SHOW_CYCLES = PRESCALE - BLANK_CYCLES;

    scan_state_t             state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [IDX_W-1:0]        idx_next;
    logic                    frame_end;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    logic [4*NUM_DIGITS-1:0] act_digits, pend_digits;
    logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
    logic                    act_lzb, pend_lzb, pend_valid;

    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic [7:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_run;
    logic [7:0]              an_all;

    assign ready = ~pend_valid;

    // Single shared decoder fed from the active-digit mux.
    assign cur_nibble = act_digits[{digit_idx, 2'b00} +: 4];
    assign cur_dp     = act_dp[digit_idx];

    bcd_seg_dec u_dec (
        .bcd (cur_nibble),
        .dp  (cur_dp),
        .seg (dec_seg)
    );

    // lz_mask[i] is set when digit i and every higher digit are zero.
    // Digit 0 is excluded so a value of zero still shows one "0".
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (act_digits[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_run;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        idx_next   = digit_idx;
        frame_end  = 1'b0;
        seg_next   = SEG_BLANK;
        an_next    = '1;
        an_all     = an_sel(3'(digit_idx));

        case (state)
            BLANK: begin
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_next = SHOW;
                    cnt_next   = '0;
                end
            end
            SHOW: begin
                if (cnt == CNT_W'(SHOW_CYCLES - 1)) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                        idx_next  = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_next = digit_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
            end
        endcase

        // Outputs are registered from the next state so they change on the
        // edge that enters it. digit_idx only changes when entering BLANK, so
        // the current index is the right one whenever the next state is SHOW.
        if (state_next == SHOW) begin
            seg_next = {dec_seg[7], (act_lzb && lz_mask[digit_idx]) ? SEG_OFF : dec_seg[6:0]};
            an_next  = an_all[NUM_DIGITS-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BLANK;
            cnt         <= '0;
            digit_idx   <= '0;
            seg         <= SEG_BLANK;
            an          <= '1;
            act_digits  <= '0;
            act_dp      <= '0;
            act_lzb     <= 1'b0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_lzb    <= 1'b0;
            pend_valid  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            digit_idx <= idx_next;
            seg       <= seg_next;
            an        <= an_next;

            // A capture implies the pending buffer was empty, so it can never
            // collide with a transfer on the same edge.
            if (load && !pend_valid) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_lzb    <= lzb_en;
                pend_valid  <= 1'b1;
            end else if (frame_end && pend_valid) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
                act_lzb    <= pend_lzb;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lzb_en = 1'b0;
    logic        ready;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .PRESCALE     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .lzb_en    (lzb_en),
        .ready     (ready),
        .seg       (seg),
        .an        (an),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits for a fresh entry into the SHOW slot driving anode pattern pat.
    task automatic wait_enter(input logic [3:0] pat, output bit ok);
        int n;
        n = 0;
        while (an == pat && n < 40) begin wait_cycle(); n++; end
        while (an != pat && n < 80) begin wait_cycle(); n++; end
        ok = (an == pat);
    endtask

    task automatic push_frame(input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3);
        exp_q.push_back(d0);
        exp_q.push_back(d1);
        exp_q.push_back(d2);
        exp_q.push_back(d3);
    endtask

    // Pops one expected seg value per digit as each digit's SHOW slot starts.
    task automatic check_frame(input string tag);
        logic [3:0] pat;
        logic [7:0] exp;
        bit ok;
        for (int d = 0; d < 4; d++) begin
            pat = 4'b1111;
            pat[d] = 1'b0;
            wait_enter(pat, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s timeout digit%0d: an=%b required %b", tag, d, an, pat);
            end else begin
                if (seg !== exp) begin
                    failures++;
                    $display("FAIL %s seg digit%0d: got %h required %h", tag, d, seg, exp);
                end
                checks++;
                if (digit_idx !== 2'(d)) begin
                    failures++;
                    $display("FAIL %s digit_idx: got %0d required %0d", tag, digit_idx, d);
                end
            end
        end
    endtask

    // Waits for ready; it must rise right after a frame boundary (BLANK of digit 0).
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin wait_cycle(); n++; end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready timeout: ready=%b required 1", tag, ready);
        end else if (n > 0 && (an !== 4'b1111 || digit_idx !== 2'd0)) begin
            failures++;
            $display("FAIL %s ready rise position: an=%b idx=%0d required 1111/0", tag, an, digit_idx);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic z,
                           input string tag);
        wait_ready(tag);
        digits_in = d;
        dp_in     = p;
        lzb_en    = z;
        load      = 1'b1;
        wait_cycle();
        load = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL %s ready after load: got %b required 0", tag, ready);
        end
    endtask

    // Cycle-exact scan model from a reset release: 2 blank + 6 show per digit.
    task automatic check_scan(input int n, input string tag);
        int pos, d;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        for (int t = 0; t < n; t++) begin
            pos = t % 8;
            d   = (t / 8) % 4;
            exp_an = 4'b1111;
            exp_seg = 8'hFF;
            if (pos >= 2) begin
                exp_an[d] = 1'b0;
                exp_seg = 8'hC0;
            end
            checks += 4;
            if (an !== exp_an) begin
                failures++;
                $display("FAIL %s an t=%0d: got %b required %b", tag, t, an, exp_an);
            end
            if (seg !== exp_seg) begin
                failures++;
                $display("FAIL %s seg t=%0d: got %h required %h", tag, t, seg, exp_seg);
            end
            if (digit_idx !== 2'(d)) begin
                failures++;
                $display("FAIL %s digit_idx t=%0d: got %0d required %0d", tag, t, digit_idx, d);
            end
            if (ready !== 1'b1) begin
                failures++;
                $display("FAIL %s ready t=%0d: got %b required 1", tag, t, ready);
            end
            wait_cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) wait_cycle();
        checks += 4;
        if (an !== 4'b1111) begin failures++; $display("FAIL reset an: got %b required 1111", an); end
        if (seg !== 8'hFF) begin failures++; $display("FAIL reset seg: got %h required ff", seg); end
        if (digit_idx !== 2'd0) begin failures++; $display("FAIL reset idx: got %0d required 0", digit_idx); end
        if (ready !== 1'b1) begin failures++; $display("FAIL reset ready: got %b required 1", ready); end
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        check_scan(40, "idle_scan");
    endtask

    task automatic test_load_frame();
        do_load(16'h1234, 4'b0100, 1'b0, "load_1234");
        wait_ready("load_1234");
        push_frame(8'h99, 8'hB0, 8'h24, 8'hF9);
        check_frame("load_1234");
    endtask

    task automatic test_lzb();
        do_load(16'h0050, 4'b0000, 1'b1, "lzb_on");
        wait_ready("lzb_on");
        push_frame(8'hC0, 8'h92, 8'hFF, 8'hFF);
        check_frame("lzb_on");
        do_load(16'h0050, 4'b0000, 1'b0, "lzb_off");
        wait_ready("lzb_off");
        push_frame(8'hC0, 8'h92, 8'hC0, 8'hC0);
        check_frame("lzb_off");
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_load(16'h1111, 4'b0000, 1'b0, "b2b_first");
        // Second request while ready is low must be dropped.
        digits_in = 16'h2222;
        load = 1'b1;
        wait_cycle();
        load = 1'b0;
        wait_ready("b2b_first");
        push_frame(8'hF9, 8'hF9, 8'hF9, 8'hF9);
        check_frame("b2b_ignored");

        // Issue a load exactly on the boundary edge: 5 cycles after entering
        // digit 3's SHOW, the next edge is the SHOW->BLANK edge of digit 3.
        wait_enter(4'b0111, ok);
        repeat (5) wait_cycle();
        digits_in = 16'h4321;
        dp_in = 4'b0000;
        lzb_en = 1'b0;
        load = 1'b1;
        wait_cycle();
        load = 1'b0;
        checks += 3;
        if (!ok) begin failures++; $display("FAIL boundary_load sync: an=%b required 0111", an); end
        if (ready !== 1'b0) begin failures++; $display("FAIL boundary_load ready: got %b required 0", ready); end
        if (an !== 4'b1111 || digit_idx !== 2'd0) begin
            failures++;
            $display("FAIL boundary_load position: an=%b idx=%0d required 1111/0", an, digit_idx);
        end
        push_frame(8'hF9, 8'hF9, 8'hF9, 8'hF9);
        check_frame("boundary_old");
        push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
        check_frame("boundary_new");
    endtask

    task automatic test_non_bcd();
        do_load(16'h00A0, 4'b0010, 1'b0, "non_bcd");
        wait_ready("non_bcd");
        push_frame(8'hC0, 8'h7F, 8'hC0, 8'hC0);
        check_frame("non_bcd");
    endtask

    task automatic test_mid_reset();
        bit ok;
        wait_enter(4'b1011, ok);
        // Leave a pending value behind so reset must clear it too.
        do_load(16'h5555, 4'b1111, 1'b0, "mid_rst_pend");
        wait_cycle();
        rst = 1'b1;
        #1;
        checks += 5;
        if (!ok) begin failures++; $display("FAIL mid_rst sync: digit2 SHOW not reached"); end
        if (an !== 4'b1111) begin failures++; $display("FAIL mid_rst an: got %b required 1111", an); end
        if (seg !== 8'hFF) begin failures++; $display("FAIL mid_rst seg: got %h required ff", seg); end
        if (digit_idx !== 2'd0) begin failures++; $display("FAIL mid_rst idx: got %0d required 0", digit_idx); end
        if (ready !== 1'b1) begin failures++; $display("FAIL mid_rst ready: got %b required 1", ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_scan(40, "post_rst");
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_load_frame();
        test_lzb();
        test_back_to_back();
        test_non_bcd();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
